fifo_uart_tx: RTL and testbench

Serial transmitter that drains a show-ahead FIFO and sends each word as an asynchronous UART frame: start bit, data LSB first, optional parity bit, one stop bit. It sits on the read side of the team's `fifo` block. The FIFO's `empty`/`dataout` drive this block, and this block drives the FIFO's `pop`. Continuous data leaves the line with no idle gap between frames.

---
 rtl/fifo_uart_tx.sv | 122 ++++++++++++
 tb/tb_fifo_uart_tx.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_uart_tx.sv
// UART transmitter draining a show-ahead FIFO: start bit, LSB-first data,
// optional parity, one stop bit, with back-to-back frames and no idle gap.
module fifo_uart_tx #(
   parameter int width        = 8,
   parameter int clks_per_bit = 16,
   parameter int log2clks     = 4,
   parameter bit parity_en    = 1'b0,
   parameter bit parity_odd   = 1'b0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             fifo_empty,
   input  logic [width-1:0] fifo_data,
   output logic             fifo_pop,
   output logic             txd,
   output logic             busy,
   output logic             tx_done
);

   localparam int bit_w = $clog2(width) + 1;

   localparam logic [2:0] IDLE   = 3'd0;
   localparam logic [2:0] START  = 3'd1;
   localparam logic [2:0] DATA   = 3'd2;
   localparam logic [2:0] PARITY = 3'd3;
   localparam logic [2:0] STOP   = 3'd4;

   localparam logic [log2clks-1:0] bcnt_last = log2clks'(clks_per_bit - 1);
   localparam logic [bit_w-1:0]    bit_last  = bit_w'(width - 1);

   logic [2:0]          state;
   logic [log2clks-1:0] bcnt;
   logic [bit_w-1:0]    bit_cnt;
   logic [width-1:0]    shreg;
   logic [width-1:0]    shreg_next;
   logic                par_acc;
   logic                bit_end;
   logic                load;

   assign bit_end    = (bcnt == bcnt_last);
   assign shreg_next = shreg >> 1;
   // FIFO is only looked at in IDLE and on the last cycle of a stop bit
   assign load       = rst_n && !fifo_empty &&
                       ((state == IDLE) || ((state == STOP) && bit_end));

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state    <= IDLE;
         bcnt     <= '0;
         bit_cnt  <= '0;
         txd      <= 1'b1;
         busy     <= 1'b0;
         fifo_pop <= 1'b0;
         tx_done  <= 1'b0;
      end else begin
         fifo_pop <= 1'b0;
         tx_done  <= 1'b0;
         if ((state == IDLE) || bit_end) bcnt <= '0;
         else                            bcnt <= bcnt + 1'b1;
         case (state)
            IDLE: begin
               txd  <= 1'b1;
               busy <= 1'b0;
               if (load) begin
                  fifo_pop <= 1'b1;
                  busy     <= 1'b1;
                  txd      <= 1'b0;
                  state    <= START;
               end
            end
            START: if (bit_end) begin
               state   <= DATA;
               bit_cnt <= '0;
               txd     <= shreg[0];
            end
            DATA: if (bit_end) begin
               bit_cnt <= bit_cnt + 1'b1;
               if (bit_cnt == bit_last) begin
                  if (parity_en) begin
                     state <= PARITY;
                     txd   <= par_acc ^ shreg[0];
                  end else begin
                     state <= STOP;
                     txd   <= 1'b1;
                  end
               end else begin
                  txd <= shreg_next[0];
               end
            end
            PARITY: if (bit_end) begin
               state <= STOP;
               txd   <= 1'b1;
            end
            STOP: if (bit_end) begin
               tx_done <= 1'b1;
               if (load) begin
                  fifo_pop <= 1'b1;
                  txd      <= 1'b0;
                  state    <= START;
               end else begin
                  busy  <= 1'b0;
                  txd   <= 1'b1;
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Datapath: word captured on the pop edge, shifted once per data bit
   always_ff @(posedge clk) begin
      if (load) begin
         shreg   <= fifo_data;
         par_acc <= parity_odd;
      end else if ((state == DATA) && bit_end) begin
         shreg   <= shreg_next;
         par_acc <= par_acc ^ shreg[0];
      end
   end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Bench for fifo_uart_tx: three instances (no parity, even, odd) each fed by a
// queue-backed FIFO, checked cycle by cycle against a frame-level line model.
module tb_fifo_uart_tx;

   localparam int CPB = 4;

   typedef struct packed {
      logic txd;
      logic busy;
      logic pop;
      logic done;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [2:0] empty_v;
   logic [2:0] pop_v;
   logic [2:0] txd_v;
   logic [2:0] busy_v;
   logic [2:0] done_v;
   logic [2:0] hide;
   logic [7:0] data_v [3];
   logic [7:0] q0[$];
   logic [7:0] q1[$];
   logic [7:0] q2[$];
   logic [7:0] exp_words [8];
   int         checks = 0;
   int         errors = 0;

   always #5 clk = ~clk;

   fifo_uart_tx #(.width(8), .clks_per_bit(CPB), .log2clks(2), .parity_en(1'b0), .parity_odd(1'b0))
      dut_np (.clk(clk), .rst_n(rst_n), .fifo_empty(empty_v[0]), .fifo_data(data_v[0]),
              .fifo_pop(pop_v[0]), .txd(txd_v[0]), .busy(busy_v[0]), .tx_done(done_v[0]));
   fifo_uart_tx #(.width(8), .clks_per_bit(CPB), .log2clks(2), .parity_en(1'b1), .parity_odd(1'b0))
      dut_ev (.clk(clk), .rst_n(rst_n), .fifo_empty(empty_v[1]), .fifo_data(data_v[1]),
              .fifo_pop(pop_v[1]), .txd(txd_v[1]), .busy(busy_v[1]), .tx_done(done_v[1]));
   fifo_uart_tx #(.width(8), .clks_per_bit(CPB), .log2clks(2), .parity_en(1'b1), .parity_odd(1'b1))
      dut_od (.clk(clk), .rst_n(rst_n), .fifo_empty(empty_v[2]), .fifo_data(data_v[2]),
              .fifo_pop(pop_v[2]), .txd(txd_v[2]), .busy(busy_v[2]), .tx_done(done_v[2]));

   // ---------------- FIFO model ----------------
   function automatic int qsize(input int k);
      case (k)
         0:       return q0.size();
         1:       return q1.size();
         default: return q2.size();
      endcase
   endfunction

   task automatic refresh();
      empty_v[0] = (q0.size() == 0) || hide[0];
      empty_v[1] = (q1.size() == 0) || hide[1];
      empty_v[2] = (q2.size() == 0) || hide[2];
      data_v[0]  = (q0.size() != 0) ? q0[0] : 8'h00;
      data_v[1]  = (q1.size() != 0) ? q1[0] : 8'h00;
      data_v[2]  = (q2.size() != 0) ? q2[0] : 8'h00;
   endtask

   task automatic push(input int k, input logic [7:0] w);
      case (k)
         0:       q0.push_back(w);
         1:       q1.push_back(w);
         default: q2.push_back(w);
      endcase
      refresh();
   endtask

   task automatic popq(input int k);
      logic [7:0] d;
      case (k)
         0:       d = q0.pop_front();
         1:       d = q1.pop_front();
         default: d = q2.pop_front();
      endcase
   endtask

   // Advance one cycle; sample point is the falling edge. Pops are honoured here.
   task automatic tick(input logic [2:0] h);
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
         if (pop_v[k] === 1'b1) begin
            checks++;
            if (qsize(k) == 0) begin
               errors++;
               $display("FAIL pop_when_empty inst %0d: got pop=1 on empty FIFO, required pop=0", k);
            end else begin
               popq(k);
            end
         end
      end
      hide = h;
      refresh();
   endtask

   // ---------------- reference model ----------------
   // Cycle c is counted from the edge that first sees a non-empty FIFO (c=1 is the pop cycle).
   function automatic exp_t expect_at(input int k, input int c, input int m);
      exp_t       e;
      int         n, f, off, b;
      bit         pen, podd;
      logic [7:0] w;
      pen  = (k != 0);
      podd = (k == 2);
      n    = (10 + int'(pen)) * CPB;
      e    = '{txd: 1'b1, busy: 1'b0, pop: 1'b0, done: 1'b0};
      if (c >= 1 && c <= m * n) begin
         f      = (c - 1) / n;
         off    = (c - 1) % n;
         w      = exp_words[f];
         b      = off / CPB;
         e.busy = 1'b1;
         e.pop  = (off == 0);
         if (b == 0)                e.txd = 1'b0;
         else if (b <= 8)           e.txd = w[b-1];
         else if (b == 9 && pen)    e.txd = (^w) ^ podd;
         else                       e.txd = 1'b1;
      end
      if (c > 1 && (c - 1) % n == 0 && (c - 1) / n >= 1 && (c - 1) / n <= m) e.done = 1'b1;
      return e;
   endfunction

   // ---------------- scenarios ----------------
   task automatic test_reset();
      rst_n = 1'b0;
      hide  = 3'b000;
      refresh();
      repeat (3) tick(3'b000);
      for (int k = 0; k < 3; k++) begin
         checks++;
         if ({txd_v[k], busy_v[k], pop_v[k], done_v[k]} !== 4'b1000) begin
            errors++;
            $display("FAIL reset_state inst %0d: got txd/busy/pop/done=%b, required 1000", k,
                     {txd_v[k], busy_v[k], pop_v[k], done_v[k]});
         end
      end
      rst_n = 1'b1;
   endtask

   task automatic test_empty_idle();
      for (int c = 1; c <= 100; c++) begin
         tick(3'b000);
         for (int k = 0; k < 3; k++) begin
            checks++;
            if ({txd_v[k], busy_v[k], pop_v[k]} !== 3'b100) begin
               errors++;
               $display("FAIL empty_idle inst %0d cycle %0d: got txd/busy/pop=%b, required 100", k, c,
                        {txd_v[k], busy_v[k], pop_v[k]});
            end
         end
      end
   endtask

   task automatic test_single();
      exp_t e;
      int   pops = 0;
      exp_words[0] = 8'hA5;
      push(0, 8'hA5);
      for (int c = 1; c <= 50; c++) begin
         tick(3'b000);
         e = expect_at(0, c, 1);
         if (pop_v[0] === 1'b1) pops++;
         checks++;
         if ({txd_v[0], busy_v[0], pop_v[0], done_v[0]} !== e) begin
            errors++;
            $display("FAIL single cycle %0d: got txd/busy/pop/done=%b, required %b", c,
                     {txd_v[0], busy_v[0], pop_v[0], done_v[0]}, e);
         end
      end
      checks++;
      if (pops != 1) begin
         errors++;
         $display("FAIL single_pop_count: got %0d, required 1", pops);
      end
   endtask

   task automatic test_back_to_back();
      exp_t e;
      exp_words[0] = 8'h00;
      exp_words[1] = 8'hFF;
      push(0, 8'h00);
      push(0, 8'hFF);
      for (int c = 1; c <= 90; c++) begin
         tick(3'b000);
         e = expect_at(0, c, 2);
         checks++;
         if ({txd_v[0], busy_v[0], pop_v[0], done_v[0]} !== e) begin
            errors++;
            $display("FAIL back_to_back cycle %0d: got txd/busy/pop/done=%b, required %b", c,
                     {txd_v[0], busy_v[0], pop_v[0], done_v[0]}, e);
         end
      end
      checks++;
      if (qsize(0) != 0) begin
         errors++;
         $display("FAIL back_to_back_drain: got %0d words left, required 0", qsize(0));
      end
   endtask

   task automatic test_parity();
      exp_t e;
      exp_words[0] = 8'hA5;
      push(1, 8'hA5);
      push(2, 8'hA5);
      for (int c = 1; c <= 50; c++) begin
         tick(3'b000);
         for (int k = 1; k < 3; k++) begin
            e = expect_at(k, c, 1);
            checks++;
            if ({txd_v[k], busy_v[k], pop_v[k], done_v[k]} !== e) begin
               errors++;
               $display("FAIL parity inst %0d cycle %0d: got txd/busy/pop/done=%b, required %b", k, c,
                        {txd_v[k], busy_v[k], pop_v[k], done_v[k]}, e);
            end
         end
         if (c == 38) begin
            checks++;
            if (txd_v[1] !== 1'b0 || txd_v[2] !== 1'b1) begin
               errors++;
               $display("FAIL parity_bit: got even=%b odd=%b, required even=0 odd=1", txd_v[1], txd_v[2]);
            end
         end
      end
   endtask

   task automatic test_random_stream();
      exp_t e;
      int   m, n;
      for (int k = 0; k < 3; k++) begin
         m = int'($urandom_range(2, 4));
         n = (k == 0) ? 10 * CPB : 11 * CPB;
         for (int i = 0; i < m; i++) begin
            exp_words[i] = 8'($urandom);
            push(k, exp_words[i]);
         end
         for (int c = 1; c <= m * n + 6; c++) begin
            tick(3'b000);
            e = expect_at(k, c, m);
            checks++;
            if ({txd_v[k], busy_v[k], pop_v[k], done_v[k]} !== e) begin
               errors++;
               $display("FAIL random_stream inst %0d cycle %0d: got txd/busy/pop/done=%b, required %b", k, c,
                        {txd_v[k], busy_v[k], pop_v[k], done_v[k]}, e);
            end
         end
      end
   endtask

   task automatic test_ignored_empty();
      exp_t       e;
      int         push_at [4];
      logic [2:0] h;
      localparam int M = 4;
      localparam int N = 10 * CPB;
      for (int i = 0; i < M; i++) exp_words[i] = 8'($urandom);
      for (int j = 1; j < M; j++) push_at[j] = (j - 1) * N + 2 + int'($urandom_range(0, N - 3));
      push(0, exp_words[0]);
      for (int c = 1; c <= M * N + 8; c++) begin
         h = 3'b000;
         if (c < M * N && (c % N) != 0) h[0] = 1'($urandom_range(0, 1));
         tick(h);
         for (int j = 1; j < M; j++) if (push_at[j] == c) push(0, exp_words[j]);
         e = expect_at(0, c, M);
         checks++;
         if ({txd_v[0], busy_v[0], pop_v[0], done_v[0]} !== e) begin
            errors++;
            $display("FAIL ignored_empty cycle %0d: got txd/busy/pop/done=%b, required %b", c,
                     {txd_v[0], busy_v[0], pop_v[0], done_v[0]}, e);
         end
      end
   endtask

   task automatic test_reset_mid_frame();
      exp_t e;
      exp_words[0] = 8'h3C;
      push(0, 8'h3C);
      push(0, 8'hC5);
      for (int c = 1; c <= 18; c++) begin
         tick(3'b000);
         e = expect_at(0, c, 1);
         checks++;
         if (txd_v[0] !== e.txd) begin
            errors++;
            $display("FAIL pre_reset_txd cycle %0d: got %b, required %b", c, txd_v[0], e.txd);
         end
      end
      rst_n = 1'b0;
      tick(3'b000);
      rst_n = 1'b1;
      checks++;
      if ({txd_v[0], busy_v[0], pop_v[0], done_v[0]} !== 4'b1000) begin
         errors++;
         $display("FAIL mid_reset_state: got txd/busy/pop/done=%b, required 1000",
                  {txd_v[0], busy_v[0], pop_v[0], done_v[0]});
      end
      exp_words[0] = 8'hC5;
      for (int c = 1; c <= 45; c++) begin
         tick(3'b000);
         e = expect_at(0, c, 1);
         checks++;
         if ({txd_v[0], busy_v[0], pop_v[0], done_v[0]} !== e) begin
            errors++;
            $display("FAIL after_reset cycle %0d: got txd/busy/pop/done=%b, required %b", c,
                     {txd_v[0], busy_v[0], pop_v[0], done_v[0]}, e);
         end
      end
      checks++;
      if (qsize(0) != 0) begin
         errors++;
         $display("FAIL after_reset_drain: got %0d words left, required 0", qsize(0));
      end
   endtask

   initial begin
      test_reset();
      test_empty_idle();
      test_single();
      test_back_to_back();
      test_parity();
      test_random_stream();
      test_ignored_empty();
      test_reset_mid_frame();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
